// File: rtl/btn_stretch_pkg.sv
// Shared state encoding, default timing parameters and width helpers for btn_stretch.
package btn_stretch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } chan_state_e;

  localparam int unsigned DEF_HOLD_CYCLES = 10000000;
  localparam int unsigned DEF_GAP_CYCLES  = 5000000;
  localparam int unsigned DEF_MAX_PEND    = 7;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Timer must hold the larger of the two reload values.
  function automatic int unsigned timer_width(input int unsigned hold_cycles,
                                              input int unsigned gap_cycles);
    return $clog2(max_u(hold_cycles, gap_cycles) + 1);
  endfunction

  function automatic int unsigned pend_width(input int unsigned max_pend);
    return $clog2(max_pend + 1);
  endfunction

endpackage

// File: rtl/btn_stretch_chan.sv
// One stretch channel: turns each blip into a HOLD_CYCLES high pulse plus GAP_CYCLES low,
// queueing blips that arrive while busy. Optional sticky overflow flag under BTN_STRETCH_OVF_EN.
module btn_stretch_chan
  import btn_stretch_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int unsigned MAX_PEND    = DEF_MAX_PEND
) (
  input  logic Clk100M,
  input  logic Rst,
  input  logic blip,
  output logic level,
  output logic busy
`ifdef BTN_STRETCH_OVF_EN
  ,
  output logic ovf
`endif
);

  localparam int unsigned TIMER_W = timer_width(HOLD_CYCLES, GAP_CYCLES);
  localparam int unsigned PEND_W  = pend_width(MAX_PEND);

  localparam logic [TIMER_W-1:0] HOLD_LOAD = TIMER_W'(HOLD_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GAP_LOAD  = TIMER_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0]  PEND_MAX  = PEND_W'(MAX_PEND);

  chan_state_e        r_state;
  chan_state_e        w_state_nx;
  logic [TIMER_W-1:0] r_timer;
  logic [TIMER_W-1:0] w_timer_nx;
  logic [PEND_W-1:0]  r_pend;
  logic [PEND_W-1:0]  w_pend_nx;
  logic               r_level;
  logic               w_level_nx;
  logic               r_busy;
  logic               w_busy_nx;
  logic               w_active;
  logic               w_timer_done;
  logic               w_pend_full;

  assign w_active     = (r_state != ST_IDLE);
  assign w_timer_done = (r_timer == '0);
  assign w_pend_full  = (r_pend == PEND_MAX);

  // State, timer and pend register
  always_ff @(posedge Clk100M) begin
    if (Rst) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
      r_pend  <= '0;
      r_level <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_timer <= w_timer_nx;
      r_pend  <= w_pend_nx;
      r_level <= w_level_nx;
      r_busy  <= w_busy_nx;
    end
  end

  // Next-state, timer reload/countdown, queue update and registered-output precompute
  always_comb begin
    w_state_nx = r_state;
    w_timer_nx = r_timer;
    w_pend_nx  = r_pend;

    unique case (r_state)
      ST_IDLE: begin
        // A fresh blip takes priority; any queued blip then stays queued (net zero).
        if (blip) begin
          w_state_nx = ST_HOLD;
          w_timer_nx = HOLD_LOAD;
        end else if (r_pend != '0) begin
          w_state_nx = ST_HOLD;
          w_timer_nx = HOLD_LOAD;
          w_pend_nx  = r_pend - PEND_W'(1);
        end
      end
      ST_HOLD: begin
        if (w_timer_done) begin
          w_state_nx = ST_GAP;
          w_timer_nx = GAP_LOAD;
        end else begin
          w_timer_nx = r_timer - TIMER_W'(1);
        end
      end
      ST_GAP: begin
        if (w_timer_done) begin
          w_state_nx = ST_IDLE;
        end else begin
          w_timer_nx = r_timer - TIMER_W'(1);
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_timer_nx = '0;
        w_pend_nx  = '0;
      end
    endcase

    if (blip && w_active && !w_pend_full) begin
      w_pend_nx = r_pend + PEND_W'(1);
    end

    w_level_nx = (w_state_nx == ST_HOLD);
    w_busy_nx  = (w_state_nx != ST_IDLE) || (w_pend_nx != '0);
  end

  assign level = r_level;
  assign busy  = r_busy;

`ifdef BTN_STRETCH_OVF_EN
  logic r_ovf;
  logic w_ovf_set;

  assign w_ovf_set = blip && w_active && w_pend_full;

  // Sticky drop indicator, cleared only by reset
  always_ff @(posedge Clk100M) begin
    if (Rst) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_set) begin
      r_ovf <= 1'b1;
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: rtl/btn_stretch.sv
// Two independent blip-to-level stretch channels (up/down).
// Define BTN_STRETCH_OVF_EN to expose sticky upOvf/downOvf drop flags.
module btn_stretch
  import btn_stretch_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int unsigned MAX_PEND    = DEF_MAX_PEND
) (
  input  logic Clk100M,
  input  logic Rst,
  input  logic upB,
  input  logic downB,
  output logic upL,
  output logic downL,
  output logic upBusy,
  output logic downBusy
`ifdef BTN_STRETCH_OVF_EN
  ,
  output logic upOvf,
  output logic downOvf
`endif
);

  btn_stretch_chan #(
    .HOLD_CYCLES (HOLD_CYCLES),
    .GAP_CYCLES  (GAP_CYCLES),
    .MAX_PEND    (MAX_PEND)
  ) u_up (
    .Clk100M (Clk100M),
    .Rst     (Rst),
    .blip    (upB),
    .level   (upL),
    .busy    (upBusy)
`ifdef BTN_STRETCH_OVF_EN
    ,
    .ovf     (upOvf)
`endif
  );

  btn_stretch_chan #(
    .HOLD_CYCLES (HOLD_CYCLES),
    .GAP_CYCLES  (GAP_CYCLES),
    .MAX_PEND    (MAX_PEND)
  ) u_down (
    .Clk100M (Clk100M),
    .Rst     (Rst),
    .blip    (downB),
    .level   (downL),
    .busy    (downBusy)
`ifdef BTN_STRETCH_OVF_EN
    ,
    .ovf     (downOvf)
`endif
  );

endmodule

// File: tb/tb_btn_stretch.sv
// Bench for btn_stretch: directed scenarios plus random blips/resets against an interval model.
module tb_btn_stretch;

  localparam int H   = 4;
  localparam int G   = 2;
  localparam int MAX = 2;

  logic Clk100M = 1'b0;
  logic Rst     = 1'b1;
  logic upB     = 1'b0;
  logic downB   = 1'b0;
  logic upL, downL, upBusy, downBusy;
`ifdef BTN_STRETCH_OVF_EN
  logic upOvf, downOvf;
`endif

  always #5 Clk100M = ~Clk100M;

  btn_stretch #(
    .HOLD_CYCLES (H),
    .GAP_CYCLES  (G),
    .MAX_PEND    (MAX)
  ) dut (
    .Clk100M  (Clk100M),
    .Rst      (Rst),
    .upB      (upB),
    .downB    (downB),
    .upL      (upL),
    .downL    (downL),
    .upBusy   (upBusy),
    .downBusy (downBusy)
`ifdef BTN_STRETCH_OVF_EN
    ,
    .upOvf    (upOvf),
    .downOvf  (downOvf)
`endif
  );

  // Model: each channel remembers when its current pulse started and how many blips wait.
  bit m_valid [2];
  int m_start [2];
  int m_pend  [2];
  bit m_ovf   [2];
  int cyc;
  int n_vec;
  int n_miss;
  int up_hi;
  int dn_hi;

  function automatic bit m_active(input int ch, input int t);
    return m_valid[ch] && (t < m_start[ch] + H + G);
  endfunction

  function automatic bit m_level(input int ch, input int t);
    return m_valid[ch] && (t >= m_start[ch]) && (t < m_start[ch] + H);
  endfunction

  function automatic bit m_busy(input int ch, input int t);
    return m_active(ch, t) || (m_pend[ch] > 0);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge.
  task automatic step(input bit u, input bit d, input bit r);
    bit b [2];
    b[0] = u;
    b[1] = d;
    upB   = u;
    downB = d;
    Rst   = r;
    for (int ch = 0; ch < 2; ch++) begin
      if (r) begin
        m_valid[ch] = 1'b0;
        m_pend[ch]  = 0;
        m_ovf[ch]   = 1'b0;
      end else if (!m_active(ch, cyc)) begin
        if (b[ch]) begin
          m_valid[ch] = 1'b1;
          m_start[ch] = cyc + 1;
        end else if (m_pend[ch] > 0) begin
          m_pend[ch]  = m_pend[ch] - 1;
          m_valid[ch] = 1'b1;
          m_start[ch] = cyc + 1;
        end
      end else if (b[ch]) begin
        if (m_pend[ch] < MAX) m_pend[ch] = m_pend[ch] + 1;
        else                  m_ovf[ch]  = 1'b1;
      end
    end
    cyc++;
    @(posedge Clk100M);
    #1;
    check("upL",      32'(upL),      32'(m_level(0, cyc)));
    check("downL",    32'(downL),    32'(m_level(1, cyc)));
    check("upBusy",   32'(upBusy),   32'(m_busy(0, cyc)));
    check("downBusy", 32'(downBusy), 32'(m_busy(1, cyc)));
`ifdef BTN_STRETCH_OVF_EN
    check("upOvf",    32'(upOvf),    32'(m_ovf[0]));
    check("downOvf",  32'(downOvf),  32'(m_ovf[1]));
`endif
    if (upL === 1'b1)   up_hi++;
    if (downL === 1'b1) dn_hi++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
    idle(2);
  endtask

  initial begin
    cyc    = 0;
    n_vec  = 0;
    n_miss = 0;
    for (int ch = 0; ch < 2; ch++) begin
      m_valid[ch] = 1'b0;
      m_start[ch] = 0;
      m_pend[ch]  = 0;
      m_ovf[ch]   = 1'b0;
    end

    // Single blip: exactly H high cycles
    do_reset();
    up_hi = 0; dn_hi = 0;
    step(1'b1, 1'b0, 1'b0);
    idle(12);
    check("single_hi", 32'(up_hi), 32'(H));
    check("single_dn", 32'(dn_hi), 32'(0));

    // Blips at offsets 0,2,3: three pulses, no overflow
    do_reset();
    up_hi = 0;
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    idle(30);
    check("queue3_hi", 32'(up_hi), 32'(3 * H));

    // Four consecutive blips: the fourth is dropped
    do_reset();
    up_hi = 0;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
    idle(30);
    check("drop_hi", 32'(up_hi), 32'(3 * H));

    // Simultaneous up and down
    do_reset();
    up_hi = 0; dn_hi = 0;
    step(1'b1, 1'b1, 1'b0);
    idle(12);
    check("both_up", 32'(up_hi), 32'(H));
    check("both_dn", 32'(dn_hi), 32'(H));

    // Reset mid-HOLD with one pending blip
    do_reset();
    up_hi = 0;
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    idle(20);
    check("rst_hi", 32'(up_hi), 32'(2));

    // Blip in the GAP-exit cycle
    do_reset();
    up_hi = 0;
    step(1'b1, 1'b0, 1'b0);
    idle(H + G - 1);
    step(1'b1, 1'b0, 1'b0);
    idle(15);
    check("gapexit_hi", 32'(up_hi), 32'(2 * H));

    // Random traffic with varying density and occasional reset
    do_reset();
    for (int blk = 0; blk < 12; blk++) begin
      int pu;
      int pd;
      pu = int'($urandom_range(30, 1));
      pd = int'($urandom_range(30, 1));
      for (int i = 0; i < 200; i++) begin
        step($urandom_range(pu - 1, 0) == 0,
             $urandom_range(pd - 1, 0) == 0,
             $urandom_range(399, 0) == 0);
      end
    end
    idle(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
